du_frame_tx: RTL and testbench

- Debug-unit transmit framer. Sits between the pipeline-latch snapshot bus and the UART TX FIFO.
- On a start pulse it captures the NB_R_INT-bit latch/register snapshot in one cycle.
- It then sends the snapshot as a byte frame to the UART transmitter, using a valid/ready handshake.
- It lets the debug FSM dump IF/ID, ID/EX, EX/M and M/WB contents after each step or at halt.

---
 rtl/du_frame_tx.sv | 161 ++++++++++++++++
 tb/tb_du_frame_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/du_frame_tx.sv
// Debug-unit transmit framer: captures a pipeline-latch snapshot and streams it as a
// header + payload byte frame over valid/ready. Define DU_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module du_frame_tx #(
  parameter int unsigned          NB_DATA  = 341,
  parameter int unsigned          NB_BYTE  = 8,
  parameter logic [NB_BYTE-1:0]   HDR_BYTE = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [5:0]         o_byte_idx
);

  localparam int unsigned N_BYTES = (NB_DATA + NB_BYTE - 1) / NB_BYTE;
  localparam int unsigned NB_SNAP = N_BYTES * NB_BYTE;
  localparam int unsigned NB_IDX  = 6;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
`ifdef DU_FRAME_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NB_SNAP-1:0]   snap_q, snap_d;
  logic [NB_IDX-1:0]    idx_q, idx_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef DU_FRAME_CHECKSUM_EN
  logic [NB_BYTE-1:0]   csum_q, csum_d;
`endif
  logic                 xfer;

  assign xfer = tx_valid_q & i_tx_ready;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DU_FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DU_FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Snapshot is consumed by shifting right one byte per payload transfer
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef DU_FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          snap_d     = NB_SNAP'(i_data);
          state_d    = ST_HDR;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
          idx_d      = '0;
`ifdef DU_FRAME_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d   = ST_DATA;
          idx_d     = '0;
          tx_data_d = snap_q[NB_BYTE-1:0];
          snap_d    = snap_q >> NB_BYTE;
`ifdef DU_FRAME_CHECKSUM_EN
          csum_d    = csum_q ^ tx_data_q;
`endif
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef DU_FRAME_CHECKSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef DU_FRAME_CHECKSUM_EN
            state_d   = ST_CHK;
            tx_data_d = csum_q ^ tx_data_q;
`else
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            idx_d     = idx_q + NB_IDX'(1);
            tx_data_d = snap_q[NB_BYTE-1:0];
            snap_d    = snap_q >> NB_BYTE;
          end
        end
      end
`ifdef DU_FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          state_d    = ST_DONE;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        idx_d     = '0;
        tx_data_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_byte_idx = idx_q;

endmodule

// File: tb/tb_du_frame_tx.sv
// Self-checking bench for du_frame_tx: hand-written vector table, corner sequences,
// and randomized frames compared against a byte-list reference model.
module tb_du_frame_tx;

  localparam int unsigned NB_DATA = 341;
  localparam int unsigned N_BYTES = 43;
  localparam int unsigned PADW    = N_BYTES * 8;
`ifdef DU_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = N_BYTES + 2;
  localparam bit          CHK_ON    = 1'b1;
`else
  localparam int unsigned FRAME_LEN = N_BYTES + 1;
  localparam bit          CHK_ON    = 1'b0;
`endif
  localparam int BUDGET = 3000;

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic               i_start;
  logic [NB_DATA-1:0] i_data;
  logic               i_tx_ready;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               o_busy;
  logic               o_done;
  logic [5:0]         o_byte_idx;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [NB_DATA-1:0] data;
    int                 mode;
    logic [7:0]         b0;
    logic [7:0]         b1;
    logic [7:0]         b2;
    logic [7:0]         blast;
    logic [7:0]         bchk;
  } vec_t;

  vec_t vecs[4];

  du_frame_tx dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_data     (i_data),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_byte_idx (o_byte_idx)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(o_tx_data),  32'h0);
    check({tag, "_valid"}, 32'(o_tx_valid), 32'h0);
    check({tag, "_busy"},  32'(o_busy),     32'h0);
    check({tag, "_done"},  32'(o_done),     32'h0);
    check({tag, "_idx"},   32'(o_byte_idx), 32'h0);
  endtask

  // Reference frame: header, little-endian zero-padded payload bytes, optional XOR of all sent bytes
  function automatic void model_frame(input logic [NB_DATA-1:0] d);
    logic [PADW-1:0] padded;
    logic [7:0]      x;
    padded = PADW'(d);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'hA5;
    for (int k = 0; k < int'(N_BYTES); k++) begin
      exp_q.push_back(padded[8*k +: 8]);
      x = x ^ padded[8*k +: 8];
    end
    if (CHK_ON) exp_q.push_back(x);
  endfunction

  function automatic logic ready_fn(input int mode, input int s);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       r = ((s % 6) == 0) || ((s % 6) == 3) || ((s % 6) == 5);
      default: r = ($urandom_range(0, 2) != 0);
    endcase
    return r;
  endfunction

  task automatic run_frame(input logic [NB_DATA-1:0] data, input int mode,
                           input int restart_at, input int reset_at, input bit chk_lat);
    int   cycles, step, stall_viol, idx_viol, extra, n;
    bit   prev_stall, done_ok, aborted, restarted;
    logic rdy;
    logic [7:0] prev_data;
    logic [5:0] prev_idx;
    model_frame(data);
    got.delete();
    cycles = 0; step = 0; stall_viol = 0; idx_viol = 0; extra = 0;
    prev_stall = 1'b0; done_ok = 1'b0; aborted = 1'b0; restarted = 1'b0;
    prev_data = '0; prev_idx = '0;
    @(negedge i_clk);
    i_data     = data;
    i_start    = 1'b1;
    i_tx_ready = 1'b1;
    while (cycles < BUDGET && !done_ok && !aborted) begin
      @(negedge i_clk);
      cycles++;
      i_start = 1'b0;
      if (o_byte_idx > 6'(N_BYTES - 1)) idx_viol++;
      if (o_done) begin
        done_ok = 1'b1;
        check("busy_in_done", 32'(o_busy), 32'h1);
        check("valid_in_done", 32'(o_tx_valid), 32'h0);
        if (restart_at >= 0) i_start = 1'b1;
      end else begin
        if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data || o_byte_idx !== prev_idx))
          stall_viol++;
        if (!o_busy) idx_viol++;
        if (reset_at >= 0 && got.size() == reset_at) begin
          aborted   = 1'b1;
          i_reset_n = 1'b0;
          #1;
          check_reset_outputs("abort");
        end else begin
          rdy        = ready_fn(mode, step);
          step++;
          i_tx_ready = rdy;
          if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
            i_start   = 1'b1;
            i_data    = '1;
            restarted = 1'b1;
          end
          prev_stall = o_tx_valid && !rdy;
          prev_data  = o_tx_data;
          prev_idx   = o_byte_idx;
          if (o_tx_valid && rdy) begin
            n = got.size();
            if (n >= 1 && n <= int'(N_BYTES) && o_byte_idx !== 6'(n - 1)) idx_viol++;
            got.push_back(o_tx_data);
          end
        end
      end
    end
    if (aborted) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge i_clk);
        if (o_done || o_tx_valid || o_busy) extra++;
      end
      check("abort_quiet", 32'(extra), 32'h0);
      i_reset_n = 1'b1;
    end else begin
      check("frame_done", 32'(done_ok), 32'h1);
      if (chk_lat) check("latency", 32'(cycles), 32'(FRAME_LEN + 1));
      check("frame_len", 32'(got.size()), 32'(FRAME_LEN));
      for (int k = 0; k < int'(FRAME_LEN) && k < got.size(); k++)
        check($sformatf("byte%0d", k), 32'(got[k]), 32'(exp_q[k]));
      check("stall_stable", 32'(stall_viol), 32'h0);
      check("idx_busy_track", 32'(idx_viol), 32'h0);
      @(negedge i_clk);
      i_start = 1'b0;
      check("busy_after_done", 32'(o_busy), 32'h0);
      check("done_one_cycle", 32'(o_done), 32'h0);
      check("idx_after_done", 32'(o_byte_idx), 32'h0);
      for (int c = 0; c < 5; c++) begin
        @(negedge i_clk);
        if (o_tx_valid || o_done || o_busy) extra++;
      end
      check("no_second_frame", 32'(extra), 32'h0);
    end
  endtask

  initial begin
    int idle_bad;
    logic [351:0] rnd;
    i_reset_n  = 1'b0;
    i_start    = 1'b0;
    i_tx_ready = 1'b0;
    i_data     = '0;

    vecs[0].data = '0;                      vecs[0].mode = 0;
    vecs[0].b0 = 8'hA5; vecs[0].b1 = 8'h00; vecs[0].b2 = 8'h00; vecs[0].blast = 8'h00; vecs[0].bchk = 8'hA5;
    vecs[1].data = '1;                      vecs[1].mode = 0;
    vecs[1].b0 = 8'hA5; vecs[1].b1 = 8'hFF; vecs[1].b2 = 8'hFF; vecs[1].blast = 8'h1F; vecs[1].bchk = 8'hBA;
    vecs[2].data = NB_DATA'(16'h1234);      vecs[2].mode = 1;
    vecs[2].b0 = 8'hA5; vecs[2].b1 = 8'h34; vecs[2].b2 = 8'h12; vecs[2].blast = 8'h00; vecs[2].bchk = 8'h83;
    vecs[3].data = NB_DATA'(1) << 340;      vecs[3].mode = 0;
    vecs[3].b0 = 8'hA5; vecs[3].b1 = 8'h00; vecs[3].b2 = 8'h00; vecs[3].blast = 8'h10; vecs[3].bchk = 8'hB5;

    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      i_start = ~i_start;
      i_data  = '1;
      check_reset_outputs("reset");
    end
    @(negedge i_clk);
    i_start   = 1'b0;
    i_reset_n = 1'b1;
    idle_bad  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_tx_valid || o_busy || o_done) idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'h0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].data, vecs[v].mode, -1, -1, vecs[v].mode == 0);
      if (got.size() == FRAME_LEN) begin
        check($sformatf("vec%0d_hdr", v),  32'(got[0]), 32'(vecs[v].b0));
        check($sformatf("vec%0d_b0", v),   32'(got[1]), 32'(vecs[v].b1));
        check($sformatf("vec%0d_b1", v),   32'(got[2]), 32'(vecs[v].b2));
        check($sformatf("vec%0d_last", v), 32'(got[N_BYTES]), 32'(vecs[v].blast));
        if (CHK_ON) check($sformatf("vec%0d_chk", v), 32'(got[FRAME_LEN-1]), 32'(vecs[v].bchk));
      end
    end

    run_frame(NB_DATA'(16'h1234), 0, 10, -1, 1'b1);

    run_frame(NB_DATA'(32'hDEADBEEF), 0, -1, 20, 1'b0);
    run_frame('1, 0, -1, -1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      rnd = '0;
      for (int w = 0; w < 11; w++) rnd = {rnd[319:0], 32'($urandom())};
      run_frame(NB_DATA'(rnd), 2, -1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
